// File: rtl/fpu_issue_queue.sv
`default_nettype none
// ============================================================================
// Module   : fpu_issue_queue
// Purpose  : DEPTH-entry FIFO of FPU instructions with a start/done issue FSM.
//            Optional macro FPU_ISSUE_OPCHECK_EN drops opcodes 4..7 at intake.
// Revision : 1.0  initial release
// ============================================================================
module fpu_issue_queue #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [2:0]               in_op,
    input  logic [1:0]               in_rmode,
    input  logic [31:0]              in_opa,
    input  logic [31:0]              in_opb,
    output logic                     fpu_start,
    output logic [2:0]               fpu_op,
    output logic [1:0]               rmode,
    output logic [31:0]              opa,
    output logic [31:0]              opb,
    input  logic                     fpu_done,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     illegal_op,
    output logic [15:0]              issued_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = 3 + 2 + 32 + 32;
    localparam logic [CW-1:0] C_FULL = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [EW-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic          w_accept;
    logic          w_push;
    logic          w_pop;

    // Ready comes from the registered count only, so a same-cycle pop never frees a slot.
    assign in_ready = (count < C_FULL);
    assign w_accept = in_valid && in_ready;

`ifdef FPU_ISSUE_OPCHECK_EN
    assign w_push = w_accept && !in_op[2];

    always_ff @(posedge clk) begin
        if (rst) begin
            illegal_op <= 1'b0;
        end else begin
            illegal_op <= w_accept && in_op[2];
        end
    end
`else
    assign w_push     = w_accept;
    assign illegal_op = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        fpu_start   = 1'b0;
        w_pop       = 1'b0;
        busy        = (r_state != IDLE);
        case (r_state)
            IDLE: begin
                if (count != '0) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                fpu_start   = 1'b1;
                w_state_nxt = WAIT;
            end
            WAIT: begin
                if (fpu_done) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {in_op, in_rmode, in_opa, in_opb};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            count    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Issued fields move only on the pop, keeping them stable through the done cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            fpu_op <= '0;
            rmode  <= '0;
            opa    <= '0;
            opb    <= '0;
        end else if (w_pop) begin
            {fpu_op, rmode, opa, opb} <= r_mem[r_rd_ptr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            issued_cnt <= '0;
        end else if ((r_state == WAIT) && fpu_done) begin
            issued_cnt <= issued_cnt + 16'd1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fpu_issue_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_fpu_issue_queue
// Purpose  : Self-checking bench for fpu_issue_queue (vectors, sequences, random).
// Revision : 1.0  initial release
// ============================================================================
module tb_fpu_issue_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, fpu_start, fpu_done, busy, illegal_op;
    logic [2:0]  in_op, fpu_op;
    logic [1:0]  in_rmode, rmode;
    logic [31:0] in_opa, in_opb, opa, opb;
    logic [2:0]  count;
    logic [15:0] issued_cnt;

    fpu_issue_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rmode(in_rmode), .in_opa(in_opa), .in_opb(in_opb),
        .fpu_start(fpu_start), .fpu_op(fpu_op), .rmode(rmode), .opa(opa), .opb(opb),
        .fpu_done(fpu_done), .busy(busy), .count(count), .illegal_op(illegal_op),
        .issued_cnt(issued_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  op;
        logic [1:0]  rm;
        logic [31:0] a;
        logic [31:0] b;
    } ent_t;

    typedef struct {
        logic        v;
        logic [2:0]  op;
        logic [31:0] a, b;
        logic        done;
        int          e_count;
        logic        e_ready, e_start, e_busy;
        logic [31:0] e_opa, e_opb;
        int          e_cnt;
    } vec_t;

    int tests = 0;
    int fails = 0;

    // Reference: a queue of waiting instructions plus the instruction in flight.
    ent_t        mq[$];
    ent_t        m_cur;
    bit          m_busy, m_pend, m_ill;
    logic [15:0] m_cnt;

    logic [31:0] starts[$];
    int          ill_pulses;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit   acc;
        ent_t e;
        if (rst) begin
            mq.delete();
            m_cur = '0; m_busy = 0; m_pend = 0; m_ill = 0; m_cnt = '0;
        end else begin
            acc   = in_valid && (mq.size() < DEPTH);
            e     = '{op: in_op, rm: in_rmode, a: in_opa, b: in_opb};
            m_ill = 0;
            if (!m_busy && mq.size() != 0) begin
                m_cur  = mq.pop_front();
                m_busy = 1;
                m_pend = 1;
            end else if (m_pend) begin
                m_pend = 0;
            end else if (m_busy && fpu_done) begin
                m_busy = 0;
                m_cnt  = m_cnt + 16'd1;
            end
            if (acc) begin
`ifdef FPU_ISSUE_OPCHECK_EN
                if (in_op[2]) m_ill = 1;
                else mq.push_back(e);
`else
                mq.push_back(e);
`endif
            end
        end
    endtask

    task automatic check_model();
        chk("m_count",    32'(count),      32'(mq.size()));
        chk("m_in_ready", 32'(in_ready),   32'(mq.size() < DEPTH));
        chk("m_start",    32'(fpu_start),  32'(m_pend));
        chk("m_busy",     32'(busy),       32'(m_busy));
        chk("m_op",       32'(fpu_op),     32'(m_cur.op));
        chk("m_rmode",    32'(rmode),      32'(m_cur.rm));
        chk("m_opa",      opa,             m_cur.a);
        chk("m_opb",      opb,             m_cur.b);
        chk("m_icnt",     32'(issued_cnt), 32'(m_cnt));
        chk("m_illegal",  32'(illegal_op), 32'(m_ill));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_model();
        if (fpu_start) starts.push_back(opa);
        if (illegal_op) ill_pulses++;
    endtask

    task automatic idle_inputs();
        in_valid = 0; in_op = '0; in_rmode = '0; in_opa = '0; in_opb = '0; fpu_done = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        step();
        rst = 0;
        starts.delete();
        ill_pulses = 0;
    endtask

    task automatic check_reset_values(string tag);
        chk({tag, "_count"}, 32'(count), 32'd0);
        chk({tag, "_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_start"}, 32'(fpu_start), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_fields"}, {27'd0, fpu_op, rmode}, 32'd0);
        chk({tag, "_opa"}, opa, 32'd0);
        chk({tag, "_opb"}, opb, 32'd0);
        chk({tag, "_icnt"}, 32'(issued_cnt), 32'd0);
        chk({tag, "_illegal"}, 32'(illegal_op), 32'd0);
    endtask

    task automatic push(logic [2:0] op, logic [31:0] a);
        in_valid = 1; in_op = op; in_rmode = a[1:0]; in_opa = a; in_opb = ~a;
        step();
        in_valid = 0;
    endtask

    // FPU with latency 1: done in the first WAIT cycle.
    task automatic drain(int budget);
        for (int i = 0; i < budget; i++) begin
            fpu_done = busy && !fpu_start;
            step();
        end
        fpu_done = 0;
    endtask

    vec_t tbl[7];

    initial begin
        tbl[0] = '{1, 3'd0, 32'h3F800000, 32'h40000000, 0, 1, 1, 0, 0, 32'h0, 32'h0, 0};
        tbl[1] = '{0, 3'd0, 32'h0, 32'h0, 0, 0, 1, 1, 1, 32'h3F800000, 32'h40000000, 0};
        tbl[2] = '{0, 3'd0, 32'h0, 32'h0, 0, 0, 1, 0, 1, 32'h3F800000, 32'h40000000, 0};
        tbl[3] = '{0, 3'd0, 32'h0, 32'h0, 0, 0, 1, 0, 1, 32'h3F800000, 32'h40000000, 0};
        tbl[4] = '{0, 3'd0, 32'h0, 32'h0, 0, 0, 1, 0, 1, 32'h3F800000, 32'h40000000, 0};
        tbl[5] = '{0, 3'd0, 32'h0, 32'h0, 1, 0, 1, 0, 0, 32'h3F800000, 32'h40000000, 1};
        tbl[6] = '{0, 3'd0, 32'h0, 32'h0, 0, 0, 1, 0, 0, 32'h3F800000, 32'h40000000, 1};

        do_reset();
        check_reset_values("reset");

        // Single ADD, vector table
        for (int i = 0; i < 7; i++) begin
            in_valid = tbl[i].v; in_op = tbl[i].op; in_rmode = 2'd0;
            in_opa = tbl[i].a; in_opb = tbl[i].b; fpu_done = tbl[i].done;
            step();
            chk("vec_count", 32'(count), 32'(tbl[i].e_count));
            chk("vec_ready", 32'(in_ready), 32'(tbl[i].e_ready));
            chk("vec_start", 32'(fpu_start), 32'(tbl[i].e_start));
            chk("vec_busy", 32'(busy), 32'(tbl[i].e_busy));
            chk("vec_opa", opa, tbl[i].e_opa);
            chk("vec_opb", opb, tbl[i].e_opb);
            chk("vec_icnt", 32'(issued_cnt), 32'(tbl[i].e_cnt));
        end
        idle_inputs();

        // Fill and back-pressure
        do_reset();
        for (int i = 0; i < 6; i++) begin
            in_valid = 1; in_op = 3'(i % 4); in_rmode = 2'(i); in_opa = 32'(101 + i); in_opb = 32'(i);
            step();
            if (i == 4) begin
                chk("fill_count", 32'(count), 32'd4);
                chk("fill_ready", 32'(in_ready), 32'd0);
            end
        end
        in_valid = 0;
        chk("fill_6th_count", 32'(count), 32'd4);
        drain(30);
        chk("fill_nstarts", 32'(starts.size()), 32'd5);
        for (int i = 0; i < 5; i++)
            chk("fill_order", (i < starts.size()) ? starts[i] : 32'hDEAD, 32'(101 + i));
        chk("fill_icnt", 32'(issued_cnt), 32'd5);

        // Simultaneous push and pop
        do_reset();
        push(3'd1, 32'h0000_00A0);
        chk("pp_count1", 32'(count), 32'd1);
        push(3'd2, 32'h0000_00B1);
        chk("pp_count_same", 32'(count), 32'd1);
        chk("pp_first_opa", opa, 32'h0000_00A0);
        drain(12);
        chk("pp_nstarts", 32'(starts.size()), 32'd2);
        chk("pp_second", (starts.size() > 1) ? starts[1] : 32'hDEAD, 32'h0000_00B1);

        // Pointer wrap with 10 streamed instructions
        do_reset();
        begin
            int  idx = 0;
            bit  acc;
            for (int cyc = 0; cyc < 200 && (idx < 10 || busy || count != 0); cyc++) begin
                in_valid = (idx < 10); in_op = 3'(idx % 4); in_rmode = 2'(idx);
                in_opa = 32'(idx + 1); in_opb = 32'(idx * 7);
                fpu_done = busy && !fpu_start;
                acc = in_valid && in_ready;
                step();
                if (acc) idx++;
            end
            idle_inputs();
        end
        chk("wrap_nstarts", 32'(starts.size()), 32'd10);
        for (int i = 0; i < 10; i++)
            chk("wrap_order", (i < starts.size()) ? starts[i] : 32'hDEAD, 32'(i + 1));
        chk("wrap_icnt", 32'(issued_cnt), 32'd10);

        // Illegal opcode
        do_reset();
        push(3'd5, 32'h0000_0055);
`ifdef FPU_ISSUE_OPCHECK_EN
        chk("ill_pulse", 32'(illegal_op), 32'd1);
        chk("ill_count0", 32'(count), 32'd0);
`else
        chk("ill_pulse", 32'(illegal_op), 32'd0);
`endif
        push(3'd3, 32'h0000_0033);
        chk("ill_after", 32'(illegal_op), 32'd0);
        drain(12);
`ifdef FPU_ISSUE_OPCHECK_EN
        chk("ill_pulses", 32'(ill_pulses), 32'd1);
        chk("ill_nstarts", 32'(starts.size()), 32'd1);
        chk("ill_issued", (starts.size() > 0) ? starts[0] : 32'hDEAD, 32'h0000_0033);
`else
        chk("ill_pulses", 32'(ill_pulses), 32'd0);
        chk("ill_nstarts", 32'(starts.size()), 32'd2);
        chk("ill_issued", (starts.size() > 1) ? starts[1] : 32'hDEAD, 32'h0000_0033);
`endif

        // Reset while waiting on the FPU
        do_reset();
        push(3'd0, 32'h11); in_valid = 1;
        push(3'd1, 32'h22); in_valid = 1;
        push(3'd2, 32'h33);
        chk("rw_count", 32'(count), 32'd2);
        chk("rw_busy", 32'(busy), 32'd1);
        rst = 1;
        step();
        rst = 0;
        check_reset_values("rw_reset");
        fpu_done = 1;
        step();
        fpu_done = 0;
        chk("rw_icnt", 32'(issued_cnt), 32'd0);
        chk("rw_busy_after", 32'(busy), 32'd0);

        // Random traffic against the reference model
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            rst      = ($urandom_range(0, 299) == 0);
            in_valid = $urandom_range(0, 1) == 1;
            in_op    = 3'($urandom_range(0, 7));
            in_rmode = 2'($urandom_range(0, 3));
            in_opa   = $urandom;
            in_opb   = $urandom;
            fpu_done = ($urandom_range(0, 3) == 0);
            step();
        end
        rst = 0;
        idle_inputs();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fpu_issue_queue.md
# fpu_issue_queue

Buffers FPU instructions (opcode, rounding mode, two single-precision operands) from the instruction source and issues them one at a time to the FPU datapath, which sits directly downstream. It is a DEPTH-entry FIFO with a valid/ready input handshake and a start/done issue FSM. It holds operands and controls stable at the FPU inputs for the full duration of each operation.

## Interface
- DEPTH, 4: FIFO entries; power of two, minimum 2.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  the instruction on the in_* fields is offered.
- in_ready  out  1  the queue can accept an instruction this cycle.
- in_op  in  3  fpu_op_t: ADD=0, SUB=1, MULT=2, DIV=3; 4–7 illegal.
- in_rmode  in  2  rmode_t: 0 nearest-even, 1 to-zero, 2 up, 3 down.
- in_opa, in_opb  in  32  float_t operands {sign, exponent[7:0], mantissa[22:0]}.
- fpu_start  out  1  one-cycle issue strobe to the FPU.
- fpu_op  out  3, rmode out 2, opa out 32, opb out 32  the issued instruction, registered.
- fpu_done  in  1  the FPU has finished the current operation.
- busy  out  1  the FSM is not in IDLE.
- count  out  $clog2(DEPTH)+1  current FIFO occupancy.
- illegal_op  out  1  one-cycle pulse when an illegal opcode is dropped.
- issued_cnt  out  16  number of completed operations; wraps at 0xFFFF→0.

## Operation
- Push occurs when in_valid && in_ready. in_ready = (count < DEPTH), derived from registered count only.
- When full, in_ready=0 even if a pop happens in the same cycle. There is no bypass.
- FIFO storage uses circular read/write pointers, log2(DEPTH) bits each, which wrap naturally. count increments on push and decrements on pop; a simultaneous push and pop leaves count unchanged.
- FSM states:
  - IDLE: if count != 0, latch the head entry into fpu_op/rmode/opa/opb, pop it, and go to ISSUE.
  - ISSUE: fpu_start=1 for exactly this cycle; go to WAIT unconditionally.
  - WAIT: hold all outputs. On fpu_done, increment issued_cnt and go to IDLE. Otherwise stay in WAIT.
- fpu_done is sampled only in WAIT and ignored in IDLE and ISSUE. The FPU asserts done no earlier than the cycle after fpu_start.
- The issued fields change only on the IDLE→ISSUE transition and are stable from ISSUE through the done cycle.
- busy = (state != IDLE).

## Timing
- Reset values:
  - All-zero outputs: count=0, fpu_start=0, fpu_op=0, rmode=0, opa=0, opb=0, busy=0, illegal_op=0, issued_cnt=0.
  - in_ready=1.
  - FSM in IDLE; pointers at 0.
- Reset mid-operation: the FIFO contents are discarded and the FSM returns to IDLE. A subsequent fpu_done is ignored. The FPU is expected to be reset by the same rst.
- Latency with an empty queue and idle FSM:
  - push at edge N → count=1 after N;
  - IDLE→ISSUE at edge N+1 (pop);
  - fpu_start high during cycle N+1..N+2.
- Push to fpu_start: 1 cycle minimum.
- Throughput: back-to-back instructions are issued every (FPU latency + 2) cycles; the done cycle goes to IDLE, and the next ISSUE follows one edge later.

## Configuration
- Macro: FPU_ISSUE_OPCHECK_EN.
- Defined:
  - An accepted instruction with in_op ∈ {4..7} is consumed (handshake completes) but is not written.
  - count is unchanged, and illegal_op pulses high in the cycle after acceptance.
- Undefined:
  - All opcodes are queued and issued unchanged.
  - illegal_op is tied to 0.

## Test plan
- Single ADD: after reset, push op=0, rmode=0, opa=0x3F800000, opb=0x40000000.
  - Required: fpu_start one cycle later with those values.
  - Hold fpu_done low for 3 cycles and then pulse it: the outputs stay stable, busy drops the cycle after done, and issued_cnt=1.
- Fill and back-pressure: with fpu_done held low, push 5 instructions with DEPTH=4.
  - Required: the first is issued, and 4 remain queued (count=4, in_ready=0). The 6th offer is not accepted.
  - Done pulses must then issue the remaining instructions in FIFO order.
- Simultaneous push/pop: with count=1 and the FSM in IDLE, push in the same cycle as the pop.
  - Required: count stays 1, and the next issue carries the pushed data.
- Pointer wrap: stream 10 instructions with distinct opa values 1..10 and an FPU latency of 1.
  - Required: the issued opa sequence is 1..10 and issued_cnt=10.
- Illegal opcode (macro defined): push op=5 then op=3.
  - Required: illegal_op pulses once, count reaches 1, and only op=3 (DIV) is issued.
- Reset in WAIT: assert rst for 1 cycle with count=2.
  - Required: all outputs are at reset values the next cycle, and a following fpu_done is ignored (issued_cnt=0).
